// File: rtl/mure_pkg.sv
// Shared types for the trace-encoder commit path: FIFO entry layout,
// instruction-type encodings and the commit scheduler state encoding.
package mure_pkg;

  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned IADDR_W   = 32;
  localparam int unsigned PRIV_W    = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_STD = ITYPE_LEN'(0);
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = ITYPE_LEN'(2);

  // One retired-instruction slot as it sits at the head of a commit FIFO
  typedef struct packed {
    logic                 valid;
    logic [ITYPE_LEN-1:0] itype;
    logic [IADDR_W-1:0]   iaddr;
    logic [PRIV_W-1:0]    priv;
  } fifo_entry_s;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SLOT0 = 2'd1,
    S_SLOT1 = 2'd2
  } sched_state_e;

  // True when the instruction type is a trap (exception or interrupt)
  function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
  endfunction

endpackage

// File: rtl/te_sched_outreg.sv
// Valid/ready output stage of the commit scheduler: captures one entry on
// load, holds it stable until accepted, and drops it on flush.
module te_sched_outreg
  import mure_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        load_i,
  input  fifo_entry_s entry_i,
  input  logic        ready_i,
  output logic        valid_o,
  output fifo_entry_s entry_o
);

  // Output valid/entry register; a load wins over an accept in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      entry_o <= '0;
    end else begin
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (load_i) begin
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      if (load_i && !flush_i) begin
        entry_o <= entry_i;
      end
    end
  end

endmodule

// File: rtl/te_commit_scheduler.sv
// Serialises the lock-step commit-port FIFO heads into the ingress FSM, port 0
// first, skipping empty slots and dropping port 1 when port 0 traps.
// Optional statistics counters are built when TE_SCHED_STATS_EN is defined.
module te_commit_scheduler
  import mure_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  fifo_entry_s      fifo0_entry_i,
  input  fifo_entry_s      fifo1_entry_i,
  input  logic             fifo0_empty_i,
  input  logic             fifo1_empty_i,
  output logic             pop_o,
  input  logic             flush_i,
  output fifo_entry_s      entry_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] fwd_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  sched_state_e state_q, state_d;
  logic         head_rdy;
  logic         out_free;
  logic         exc0;
  logic         load;
  logic         load_sel;
  fifo_entry_s  load_entry;

  assign head_rdy   = !fifo0_empty_i && !fifo1_empty_i;
  assign out_free   = !valid_o || ready_i;
  assign exc0       = is_trap(fifo0_entry_i.itype);
  assign load_entry = load_sel ? fifo1_entry_i : fifo0_entry_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, load strobe and pop; flush overrides everything
  always_comb begin
    state_d  = state_q;
    pop_o    = 1'b0;
    load     = 1'b0;
    load_sel = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (head_rdy) state_d = S_SLOT0;
      end
      S_SLOT0: begin
        if (fifo0_entry_i.valid) begin
          if (out_free) begin
            load = 1'b1;
            if (exc0 || !fifo1_entry_i.valid) begin
              pop_o   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_SLOT1;
            end
          end
        end else if (fifo1_entry_i.valid) begin
          state_d = S_SLOT1;
        end else begin
          pop_o   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SLOT1: begin
        if (out_free) begin
          load     = 1'b1;
          load_sel = 1'b1;
          pop_o    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      pop_o   = 1'b0;
      load    = 1'b0;
    end
  end

  te_sched_outreg u_outreg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .load_i  (load),
    .entry_i (load_entry),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .entry_o (entry_o)
  );

`ifdef TE_SCHED_STATS_EN
  logic [CNT_W-1:0] fwd_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             drop_inc;

  // A port-1 slot is dropped when a trapping port-0 entry pops a valid pair
  assign drop_inc = pop_o && (state_q == S_SLOT0) && exc0 && fifo1_entry_i.valid;

  // Saturating statistics counters; kept across flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (load && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_cnt_o  = fwd_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign fwd_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_te_commit_scheduler.sv
// Directed bench for te_commit_scheduler: pair sequencing, trap drop,
// empty slots, backpressure, flush and mid-pair reset.
module tb_te_commit_scheduler;
  import mure_pkg::*;

  localparam int unsigned CNT_W = 32;
`ifdef TE_SCHED_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  fifo_entry_s      fifo0_entry;
  fifo_entry_s      fifo1_entry;
  logic             fifo0_empty;
  logic             fifo1_empty;
  logic             pop;
  logic             flush;
  fifo_entry_s      entry;
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] fwd_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  int pop_base;
  logic [CNT_W-1:0] exp_fwd  = '0;
  logic [CNT_W-1:0] exp_drop = '0;
  logic [CNT_W-1:0] want_fwd;
  logic [CNT_W-1:0] want_drop;

  te_commit_scheduler #(.CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fifo0_entry_i (fifo0_entry),
    .fifo1_entry_i (fifo1_entry),
    .fifo0_empty_i (fifo0_empty),
    .fifo1_empty_i (fifo1_empty),
    .pop_o         (pop),
    .flush_i       (flush),
    .entry_o       (entry),
    .valid_o       (valid),
    .ready_i       (ready),
    .fwd_cnt_o     (fwd_cnt),
    .drop_cnt_o    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops counted mid-cycle, away from the active edge
  always @(negedge clk) if (pop === 1'b1) pop_cnt++;

  function automatic fifo_entry_s mk(input logic v, input logic [ITYPE_LEN-1:0] it,
                                     input logic [31:0] addr);
    fifo_entry_s e;
    e.valid = v;
    e.itype = it;
    e.iaddr = addr;
    e.priv  = 2'd3;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input fifo_entry_s e0, input fifo_entry_s e1);
    fifo0_entry = e0;
    fifo1_entry = e1;
    fifo0_empty = 1'b0;
    fifo1_empty = 1'b0;
  endtask

  task automatic test_counters(input string tag);
    want_fwd  = STATS_EN ? exp_fwd : '0;
    want_drop = STATS_EN ? exp_drop : '0;
    n_tests++; if (fwd_cnt !== want_fwd) begin n_fail++; $display("FAIL %s_fwd_cnt: got %0d want %0d", tag, fwd_cnt, want_fwd); end
    n_tests++; if (drop_cnt !== want_drop) begin n_fail++; $display("FAIL %s_drop_cnt: got %0d want %0d", tag, drop_cnt, want_drop); end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (entry !== '0) begin n_fail++; $display("FAIL reset_entry: got %h want 0", entry); end
    n_tests++; if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", pop); end
    test_counters("reset");
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_two_valid();
    fifo_entry_s a, b;
    a = mk(1'b1, ITYPE_STD, 32'h0000_1000);
    b = mk(1'b1, ITYPE_STD, 32'h0000_1004);
    pop_base = pop_cnt;
    cyc(); drive_pair(a, b); ready = 1'b1; #1;
    n_tests++; if (pop !== 1'b0) begin n_fail++; $display("FAIL two_idle_pop: got %b want 0", pop); end
    cyc();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL two_slot0_valid: got %b want 0", valid); end
    n_tests++; if (pop !== 1'b0) begin n_fail++; $display("FAIL two_slot0_pop: got %b want 0", pop); end
    cyc();
    n_tests++; if (valid !== 1'b1 || entry !== a) begin n_fail++; $display("FAIL two_first_out: got v=%b %h want v=1 %h", valid, entry, a); end
    n_tests++; if (pop !== 1'b1) begin n_fail++; $display("FAIL two_slot1_pop: got %b want 1", pop); end
    cyc(); fifo0_empty = 1'b1; fifo1_empty = 1'b1; #1;
    n_tests++; if (valid !== 1'b1 || entry !== b) begin n_fail++; $display("FAIL two_second_out: got v=%b %h want v=1 %h", valid, entry, b); end
    cyc();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL two_drain_valid: got %b want 0", valid); end
    n_tests++; if (pop_cnt - pop_base != 1) begin n_fail++; $display("FAIL two_pop_count: got %0d want 1", pop_cnt - pop_base); end
    exp_fwd = exp_fwd + 2;
    test_counters("two");
  endtask

  task automatic test_trap_drop();
    fifo_entry_s a, b;
    a = mk(1'b1, ITYPE_EXC, 32'h0000_2000);
    b = mk(1'b1, ITYPE_STD, 32'h0000_2004);
    pop_base = pop_cnt;
    cyc(); drive_pair(a, b); #1;
    cyc();
    n_tests++; if (pop !== 1'b1) begin n_fail++; $display("FAIL trap_slot0_pop: got %b want 1", pop); end
    cyc(); fifo0_empty = 1'b1; fifo1_empty = 1'b1; #1;
    n_tests++; if (valid !== 1'b1 || entry !== a) begin n_fail++; $display("FAIL trap_out: got v=%b %h want v=1 %h", valid, entry, a); end
    cyc();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL trap_no_slot1: got %b want 0", valid); end
    n_tests++; if (pop_cnt - pop_base != 1) begin n_fail++; $display("FAIL trap_pop_count: got %0d want 1", pop_cnt - pop_base); end
    exp_fwd  = exp_fwd + 1;
    exp_drop = exp_drop + 1;
    test_counters("trap");
  endtask

  task automatic test_empty_slots();
    fifo_entry_s a, z;
    a = mk(1'b1, ITYPE_STD, 32'h0000_3000);
    z = mk(1'b0, ITYPE_STD, 32'h0000_3004);
    pop_base = pop_cnt;
    cyc(); drive_pair(a, z); #1;
    cyc();
    n_tests++; if (pop !== 1'b1) begin n_fail++; $display("FAIL single_slot0_pop: got %b want 1", pop); end
    cyc(); drive_pair(z, z); #1;
    n_tests++; if (valid !== 1'b1 || entry !== a) begin n_fail++; $display("FAIL single_out: got v=%b %h want v=1 %h", valid, entry, a); end
    cyc();
    n_tests++; if (pop !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL both_invalid: got pop=%b v=%b want pop=1 v=0", pop, valid); end
    cyc(); fifo0_empty = 1'b1; fifo1_empty = 1'b1; #1;
    n_tests++; if (pop !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL empty_idle: got pop=%b v=%b want 0 0", pop, valid); end
    n_tests++; if (pop_cnt - pop_base != 2) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 2", pop_cnt - pop_base); end
    exp_fwd = exp_fwd + 1;
    test_counters("empty");
  endtask

  task automatic test_backpressure();
    fifo_entry_s c, d;
    int bad;
    c = mk(1'b1, ITYPE_STD, 32'h0000_4000);
    d = mk(1'b1, ITYPE_INT, 32'h0000_4004);
    bad = 0;
    pop_base = pop_cnt;
    cyc(); drive_pair(c, d); ready = 1'b0; #1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (valid !== 1'b1 || entry !== c || pop !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    n_tests++; if (pop_cnt - pop_base != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops want 0", pop_cnt - pop_base); end
    cyc(); ready = 1'b1; #1;
    n_tests++; if (pop !== 1'b1 || entry !== c) begin n_fail++; $display("FAIL bp_release: got pop=%b %h want pop=1 %h", pop, entry, c); end
    cyc(); fifo0_empty = 1'b1; fifo1_empty = 1'b1; #1;
    n_tests++; if (valid !== 1'b1 || entry !== d) begin n_fail++; $display("FAIL bp_second: got v=%b %h want v=1 %h", valid, entry, d); end
    cyc();
    n_tests++; if (valid !== 1'b0 || pop_cnt - pop_base != 1) begin n_fail++; $display("FAIL bp_drain: got v=%b pops=%0d want v=0 pops=1", valid, pop_cnt - pop_base); end
    exp_fwd = exp_fwd + 2;
    test_counters("bp");
  endtask

  task automatic test_flush();
    fifo_entry_s e, f;
    e = mk(1'b1, ITYPE_STD, 32'h0000_5000);
    f = mk(1'b1, ITYPE_STD, 32'h0000_5004);
    pop_base = pop_cnt;
    cyc(); drive_pair(e, f); #1;
    cyc();
    cyc(); flush = 1'b1; #1;
    n_tests++; if (valid !== 1'b1 || pop !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got v=%b pop=%b want v=1 pop=0", valid, pop); end
    cyc(); flush = 1'b0; fifo0_empty = 1'b1; fifo1_empty = 1'b1; #1;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", valid); end
    n_tests++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL flush_state: got %0d want %0d", dut.state_q, S_IDLE); end
    n_tests++; if (pop_cnt - pop_base != 0) begin n_fail++; $display("FAIL flush_pop: got %0d pops want 0", pop_cnt - pop_base); end
    exp_fwd = exp_fwd + 1;
    test_counters("flush");
  endtask

  task automatic test_reset_mid_pair();
    fifo_entry_s g, h;
    g = mk(1'b1, ITYPE_STD, 32'h0000_6000);
    h = mk(1'b1, ITYPE_STD, 32'h0000_6004);
    cyc(); drive_pair(g, h); #1;
    cyc();
    cyc();
    n_tests++; if (valid !== 1'b1 || entry !== g) begin n_fail++; $display("FAIL rst_pre: got v=%b %h want v=1 %h", valid, entry, g); end
    rst_n = 1'b0; #1;
    n_tests++; if (valid !== 1'b0 || entry !== '0 || pop !== 1'b0) begin n_fail++; $display("FAIL rst_async: got v=%b %h pop=%b want 0 0 0", valid, entry, pop); end
    exp_fwd  = '0;
    exp_drop = '0;
    test_counters("rst_async");
    cyc();
    cyc(); rst_n = 1'b1; #1;
    pop_base = pop_cnt;
    cyc();
    n_tests++; if (valid !== 1'b0 || pop !== 1'b0) begin n_fail++; $display("FAIL rst_replay_slot0: got v=%b pop=%b want 0 0", valid, pop); end
    cyc();
    n_tests++; if (valid !== 1'b1 || entry !== g || pop !== 1'b1) begin n_fail++; $display("FAIL rst_replay_first: got v=%b %h pop=%b want v=1 %h pop=1", valid, entry, pop, g); end
    cyc(); fifo0_empty = 1'b1; fifo1_empty = 1'b1; #1;
    n_tests++; if (valid !== 1'b1 || entry !== h) begin n_fail++; $display("FAIL rst_replay_second: got v=%b %h want v=1 %h", valid, entry, h); end
    cyc();
    n_tests++; if (valid !== 1'b0 || pop_cnt - pop_base != 1) begin n_fail++; $display("FAIL rst_replay_drain: got v=%b pops=%0d want v=0 pops=1", valid, pop_cnt - pop_base); end
    exp_fwd = exp_fwd + 2;
    test_counters("rst_replay");
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    ready       = 1'b1;
    fifo0_empty = 1'b1;
    fifo1_empty = 1'b1;
    fifo0_entry = '0;
    fifo1_entry = '0;
    test_reset();
    test_two_valid();
    test_trap_drop();
    test_empty_slots();
    test_backpressure();
    test_flush();
    test_reset_mid_pair();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
